// File: rtl/ring_counter.sv
// One-hot ring counter: a single token bit rotates through WIDTH stages,
// with parallel load, direction select, one-hot integrity flag, optional
// self-correction to RESET_VALUE, and a registered wrap pulse.
module ring_counter #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {1'b1, {(WIDTH-1){1'b0}}},
    parameter bit               SELF_CORRECT = 1'b1
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] count,
    output logic             onehot_ok,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] rot_r, rot_l;

    // Both rotation candidates; dir picks one at the enabled edge.
    always_comb begin
        rot_r = {count_q[0], count_q[WIDTH-1:1]};
        rot_l = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    always_comb begin
        onehot_ok = (count_q != '0) && ((count_q & (count_q - ONE)) == '0);
    end

    // Next-state: load beats enable; a corrupted ring is either recovered
    // (not counted as a rotation, so no wrap) or rotated as-is.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_data;
        end else if (en) begin
            if (SELF_CORRECT && !onehot_ok) begin
                count_d = RESET_VALUE;
            end else begin
                count_d = dir ? rot_l : rot_r;
                wrap_d  = ((dir ? rot_l : rot_r) == RESET_VALUE);
            end
        end
    end

    // State registers with synchronous active-low initialise.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            count_q <= RESET_VALUE;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_ring_counter.sv
// Directed bench for ring_counter: one instance with self-correction, one
// without, driven by the same stimulus.
module tb_ring_counter;

    logic       clk = 1'b0;
    logic       init_n = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_data = 4'b0000;

    logic [3:0] count_sc, count_nc;
    logic       ok_sc, ok_nc, wrap_sc, wrap_nc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ring_counter #(.WIDTH(4), .RESET_VALUE(4'b1000), .SELF_CORRECT(1'b1)) u_sc (
        .clk(clk), .init_n(init_n), .en(en), .dir(dir), .load(load),
        .load_data(load_data), .count(count_sc), .onehot_ok(ok_sc), .wrap(wrap_sc)
    );

    ring_counter #(.WIDTH(4), .RESET_VALUE(4'b1000), .SELF_CORRECT(1'b0)) u_nc (
        .clk(clk), .init_n(init_n), .en(en), .dir(dir), .load(load),
        .load_data(load_data), .count(count_nc), .onehot_ok(ok_nc), .wrap(wrap_nc)
    );

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        init_n = 1'b0; en = 1'b0; load = 1'b0; dir = 1'b0;
        tick();
        checks++;
        if (count_sc !== 4'b1000 || count_nc !== 4'b1000) begin
            failures++;
            $display("FAIL reset_count sc=%b nc=%b expected 1000", count_sc, count_nc);
        end
        checks++;
        if (wrap_sc !== 1'b0 || wrap_nc !== 1'b0 || ok_sc !== 1'b1 || ok_nc !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags wrap=%b/%b ok=%b/%b expected wrap 0 ok 1",
                     wrap_sc, wrap_nc, ok_sc, ok_nc);
        end
        init_n = 1'b1;
    endtask

    task automatic test_rotate_right();
        logic [3:0] exp_c [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count_sc !== exp_c[i] || count_nc !== exp_c[i] ||
                wrap_sc !== exp_w[i] || wrap_nc !== exp_w[i] ||
                ok_sc !== 1'b1 || ok_nc !== 1'b1) begin
                failures++;
                $display("FAIL rot_right[%0d] count=%b/%b wrap=%b/%b ok=%b/%b expected count %b wrap %b ok 1",
                         i, count_sc, count_nc, wrap_sc, wrap_nc, ok_sc, ok_nc, exp_c[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_rotate_left();
        logic [3:0] exp_c [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count_sc !== exp_c[i] || count_nc !== exp_c[i] ||
                wrap_sc !== exp_w[i] || wrap_nc !== exp_w[i]) begin
                failures++;
                $display("FAIL rot_left[%0d] count=%b/%b wrap=%b/%b expected count %b wrap %b",
                         i, count_sc, count_nc, wrap_sc, wrap_nc, exp_c[i], exp_w[i]);
            end
        end
    endtask

    // Load while enabled (and while wrap is high): load wins, wrap clears.
    task automatic test_load_priority();
        load = 1'b1; load_data = 4'b0010; en = 1'b1; dir = 1'b0;
        tick();
        checks++;
        if (count_sc !== 4'b0010 || count_nc !== 4'b0010 || wrap_sc !== 1'b0 || wrap_nc !== 1'b0) begin
            failures++;
            $display("FAIL load_priority count=%b/%b wrap=%b/%b expected count 0010 wrap 0",
                     count_sc, count_nc, wrap_sc, wrap_nc);
        end
        load = 1'b0;
    endtask

    // Hold with en=0, then resume; direction switched earlier takes effect here.
    task automatic test_hold();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count_sc !== 4'b0010 || count_nc !== 4'b0010 || wrap_sc !== 1'b0 || wrap_nc !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d] count=%b/%b wrap=%b/%b expected count 0010 wrap 0",
                         i, count_sc, count_nc, wrap_sc, wrap_nc);
            end
        end
        en = 1'b1; dir = 1'b0;
        tick();
        checks++;
        if (count_sc !== 4'b0001 || count_nc !== 4'b0001) begin
            failures++;
            $display("FAIL hold_resume count=%b/%b expected 0001", count_sc, count_nc);
        end
        dir = 1'b1;
        tick();
        checks++;
        if (count_sc !== 4'b0010 || count_nc !== 4'b0010) begin
            failures++;
            $display("FAIL dir_change count=%b/%b expected 0010", count_sc, count_nc);
        end
    endtask

    task automatic test_self_correct();
        load = 1'b1; load_data = 4'b0110; en = 1'b0; dir = 1'b0;
        tick();
        checks++;
        if (count_sc !== 4'b0110 || count_nc !== 4'b0110 || ok_sc !== 1'b0 || ok_nc !== 1'b0) begin
            failures++;
            $display("FAIL load_bad count=%b/%b ok=%b/%b expected count 0110 ok 0",
                     count_sc, count_nc, ok_sc, ok_nc);
        end
        load = 1'b0; en = 1'b1;
        tick();
        checks++;
        if (count_sc !== 4'b1000 || wrap_sc !== 1'b0 || ok_sc !== 1'b1) begin
            failures++;
            $display("FAIL recover_sc count=%b wrap=%b ok=%b expected count 1000 wrap 0 ok 1",
                     count_sc, wrap_sc, ok_sc);
        end
        checks++;
        if (count_nc !== 4'b0011 || wrap_nc !== 1'b0) begin
            failures++;
            $display("FAIL nocorrect_1 count=%b wrap=%b expected count 0011 wrap 0", count_nc, wrap_nc);
        end
        tick();
        checks++;
        if (count_nc !== 4'b1001 || ok_nc !== 1'b0 || count_sc !== 4'b0100) begin
            failures++;
            $display("FAIL nocorrect_2 nc=%b ok=%b sc=%b expected nc 1001 ok 0 sc 0100",
                     count_nc, ok_nc, count_sc);
        end
    endtask

    task automatic test_load_zero();
        load = 1'b1; load_data = 4'b0000; en = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count_nc !== 4'b0000 || ok_nc !== 1'b0 || wrap_nc !== 1'b0) begin
                failures++;
                $display("FAIL zero_nc[%0d] count=%b ok=%b wrap=%b expected count 0000 ok 0 wrap 0",
                         i, count_nc, ok_nc, wrap_nc);
            end
        end
        checks++;
        if (count_sc !== 4'b0100 || wrap_sc !== 1'b0) begin
            failures++;
            $display("FAIL zero_sc count=%b wrap=%b expected count 0100 wrap 0", count_sc, wrap_sc);
        end
    endtask

    task automatic test_reset_priority();
        init_n = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        init_n = 1'b1; en = 1'b1; dir = 1'b0;
        tick();
        checks++;
        if (count_sc !== 4'b0100 || count_nc !== 4'b0100) begin
            failures++;
            $display("FAIL pre_reset count=%b/%b expected 0100", count_sc, count_nc);
        end
        init_n = 1'b0; load = 1'b1; load_data = 4'b0001; en = 1'b1;
        tick();
        checks++;
        if (count_sc !== 4'b1000 || count_nc !== 4'b1000 || wrap_sc !== 1'b0 || wrap_nc !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority count=%b/%b wrap=%b/%b expected count 1000 wrap 0",
                     count_sc, count_nc, wrap_sc, wrap_nc);
        end
        init_n = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_rotate_right();
        test_rotate_left();
        test_load_priority();
        test_hold();
        test_self_correct();
        test_load_zero();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
